// File: rtl/loader_pkg.sv
// Shared definitions for the receive-side sample loader: state encoding and
// default geometry of the sample memory.
package loader_pkg;

   localparam int          DEF_ADDR_WIDTH = 16;
   localparam logic [15:0] DEF_LAST_ADDR  = 16'hFFFF;

   // 3-bit state codes, also visible on the debug state output
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_BYTE = 3'd1;
   localparam logic [2:0] S_WRITE     = 3'd2;
   localparam logic [2:0] S_INCR      = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = S_IDLE,
      ST_WAIT_BYTE = S_WAIT_BYTE,
      ST_WRITE     = S_WRITE,
      ST_INCR      = S_INCR,
      ST_DONE      = S_DONE
   } state_t;

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle counter for the loader. Only instantiated when the
// RX_TIMEOUT_EN macro is defined.
module idle_timer #(
   parameter int TIMEOUT_CYCLES = 5_000_000,
   parameter int TO_WIDTH       = 23
) (
   input  logic iClock,
   input  logic iReset,
   input  logic iClear,
   input  logic iEnable,
   output logic oExpired
);

   logic [TO_WIDTH-1:0] r_count;
   logic                w_at_limit;

   assign w_at_limit = (r_count == TO_WIDTH'(TIMEOUT_CYCLES - 1));
   assign oExpired   = iEnable && w_at_limit;

   // Count enabled idle cycles, saturating at the limit; clear has priority
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         r_count <= '0;
      end else if (iClear) begin
         r_count <= '0;
      end else if (iEnable && !w_at_limit) begin
         r_count <= r_count + TO_WIDTH'(1);
      end
   end

endmodule

// File: rtl/rx_loader.sv
// Receive-side sample loader: writes bytes from uart_rx sequentially into
// sample memory from address 0 to LAST_ADDR, with a one-byte pending slot
// to absorb bytes that arrive while a write is in progress.
// Optional feature macro: RX_TIMEOUT_EN (inter-byte idle timeout).
//
// Strobe semantics: iRxDone is a one-cycle strobe with iRxData valid in the
// same cycle; there is no back-pressure, so a byte that finds both the
// datapath and the pending slot busy is dropped and flagged on oOverrun.
// oWrEn is a one-cycle write strobe with oAddress/oData stable alongside.
module rx_loader
   import loader_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] LAST_ADDR      = ADDR_WIDTH'(DEF_LAST_ADDR)
`ifdef RX_TIMEOUT_EN
   ,
   parameter int                    TIMEOUT_CYCLES = 5_000_000,
   parameter int                    TO_WIDTH       = 23
`endif
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  iStart,
   input  logic [7:0]            iRxData,
   input  logic                  iRxDone,
   output logic [ADDR_WIDTH-1:0] oAddress,
   output logic [7:0]            oData,
   output logic                  oWrEn,
   output logic                  oBusy,
   output logic                  oLoadFinished,
   output logic                  oOverrun,
   output logic                  oTimeout,
   output logic [2:0]            oDbgState
);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_data;
   logic                  r_wr_en;
   logic                  r_busy;
   logic                  r_finished;
   logic                  r_overrun;
   logic                  r_pend_valid;
   logic [7:0]            r_pend_data;
   logic                  w_slot_capture;

   // Bytes arriving while the datapath is busy go to the pending slot
   assign w_slot_capture = iRxDone && ((r_state == ST_WRITE) || (r_state == ST_INCR));

`ifdef RX_TIMEOUT_EN
   logic r_timeout;
   logic r_got_byte;
   logic w_tmr_clear;
   logic w_tmr_enable;
   logic w_tmr_expired;

   // Restart the idle window in IDLE (covers iStart) and on every accepted byte
   assign w_tmr_clear  = (r_state == ST_IDLE) ||
                         ((r_state == ST_WAIT_BYTE) && (r_pend_valid || iRxDone));
   assign w_tmr_enable = (r_state == ST_WAIT_BYTE) && r_got_byte;

   idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_WIDTH       (TO_WIDTH)
   ) u_idle_timer (
      .iClock   (iClock),
      .iReset   (iReset),
      .iClear   (w_tmr_clear),
      .iEnable  (w_tmr_enable),
      .oExpired (w_tmr_expired)
   );

   assign oTimeout = r_timeout;
`else
   assign oTimeout = 1'b0;
`endif

   // Load sequencer, pending slot and all registered outputs
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_data       <= '0;
         r_wr_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_finished   <= 1'b0;
         r_overrun    <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
`ifdef RX_TIMEOUT_EN
         r_timeout    <= 1'b0;
         r_got_byte   <= 1'b0;
`endif
      end else begin
         r_wr_en    <= 1'b0;
         r_finished <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_addr       <= '0;
               r_pend_valid <= 1'b0;
               if (iStart) begin
                  r_state   <= ST_WAIT_BYTE;
                  r_busy    <= 1'b1;
                  r_overrun <= 1'b0;
`ifdef RX_TIMEOUT_EN
                  r_timeout  <= 1'b0;
                  r_got_byte <= 1'b0;
`endif
               end
            end
            ST_WAIT_BYTE: begin
               if (r_pend_valid) begin
                  // Slot is older than any new strobe; a new strobe refills it
                  r_data       <= r_pend_data;
                  r_wr_en      <= 1'b1;
                  r_state      <= ST_WRITE;
                  r_pend_valid <= iRxDone;
                  if (iRxDone) begin
                     r_pend_data <= iRxData;
                  end
`ifdef RX_TIMEOUT_EN
                  r_got_byte <= 1'b1;
`endif
               end else if (iRxDone) begin
                  r_data  <= iRxData;
                  r_wr_en <= 1'b1;
                  r_state <= ST_WRITE;
`ifdef RX_TIMEOUT_EN
                  r_got_byte <= 1'b1;
`endif
               end
`ifdef RX_TIMEOUT_EN
               else if (w_tmr_expired) begin
                  r_state    <= ST_DONE;
                  r_finished <= 1'b1;
                  r_timeout  <= 1'b1;
               end
`endif
            end
            ST_WRITE: begin
               r_state <= ST_INCR;
            end
            ST_INCR: begin
               if (r_addr == LAST_ADDR) begin
                  r_state    <= ST_DONE;
                  r_finished <= 1'b1;
               end else begin
                  r_addr  <= r_addr + ADDR_WIDTH'(1);
                  r_state <= ST_WAIT_BYTE;
               end
            end
            ST_DONE: begin
               // Any byte still pending belongs to no address; drop it
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_addr       <= '0;
               r_pend_valid <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         if (w_slot_capture) begin
            if (r_pend_valid) begin
               r_overrun <= 1'b1;
            end else begin
               r_pend_valid <= 1'b1;
               r_pend_data  <= iRxData;
            end
         end
      end
   end

   assign oAddress      = r_addr;
   assign oData         = r_data;
   assign oWrEn         = r_wr_en;
   assign oBusy         = r_busy;
   assign oLoadFinished = r_finished;
   assign oOverrun      = r_overrun;
   assign oDbgState     = r_state;

endmodule

// File: tb/tb_rx_loader.sv
// Directed bench for rx_loader with LAST_ADDR=3 (four-address loads).
module tb_rx_loader;
   import loader_pkg::*;

   logic        iClock = 1'b0;
   logic        iReset = 1'b1;
   logic        iStart = 1'b0;
   logic [7:0]  iRxData = 8'h00;
   logic        iRxDone = 1'b0;
   logic [15:0] oAddress;
   logic [7:0]  oData;
   logic        oWrEn;
   logic        oBusy;
   logic        oLoadFinished;
   logic        oOverrun;
   logic        oTimeout;
   logic [2:0]  oDbgState;

   int n_vec = 0;
   int n_err = 0;
   int fin_cnt = 0;
   logic [23:0] exp_q[$];
   logic [23:0] act_q[$];

   rx_loader #(
      .ADDR_WIDTH (16),
      .LAST_ADDR  (16'd3)
`ifdef RX_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (100),
      .TO_WIDTH       (23)
`endif
   ) dut (
      .iClock        (iClock),
      .iReset        (iReset),
      .iStart        (iStart),
      .iRxData       (iRxData),
      .iRxDone       (iRxDone),
      .oAddress      (oAddress),
      .oData         (oData),
      .oWrEn         (oWrEn),
      .oBusy         (oBusy),
      .oLoadFinished (oLoadFinished),
      .oOverrun      (oOverrun),
      .oTimeout      (oTimeout),
      .oDbgState     (oDbgState)
   );

   // clock / reset
   always #5 iClock = ~iClock;

   // write and finish monitor, sampled mid-cycle
   always @(negedge iClock) begin
      if (oWrEn) act_q.push_back({oAddress, oData});
      if (oLoadFinished) fin_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_writes(input string tag);
      logic [23:0] a;
      logic [23:0] e;
      chk({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && act_q.size() > 0) begin
         a = act_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_entry"}, {8'h00, a}, {8'h00, e});
      end
      exp_q.delete();
      act_q.delete();
   endtask

   // driver tasks
   task automatic idle(input int n);
      repeat (n) @(posedge iClock);
      #1;
   endtask

   task automatic start_pulse();
      @(posedge iClock); #1 iStart = 1'b1;
      @(posedge iClock); #1 iStart = 1'b0;
   endtask

   task automatic send_now(input logic [7:0] b);
      iRxData = b;
      iRxDone = 1'b1;
      @(posedge iClock); #1 iRxDone = 1'b0;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      @(posedge iClock); #1;
      send_now(b);
   endtask

   initial begin
      // reset state
      #2 iReset = 1'b0;
      #20;
      chk("rst_addr", 32'(oAddress), 32'h0);
      chk("rst_data", 32'(oData), 32'h0);
      chk("rst_wren", 32'(oWrEn), 32'h0);
      chk("rst_busy", 32'(oBusy), 32'h0);
      chk("rst_fin", 32'(oLoadFinished), 32'h0);
      chk("rst_ovr", 32'(oOverrun), 32'h0);
      chk("rst_tmo", 32'(oTimeout), 32'h0);
      chk("rst_state", 32'(oDbgState), 32'(S_IDLE));
      @(negedge iClock) iReset = 1'b1;
      idle(2);

      // strobe while IDLE is ignored
      pulse_rx(8'hFF);
      idle(5);
      chk("idle_no_write", 32'(act_q.size()), 32'd0);
      chk("idle_addr", 32'(oAddress), 32'h0);
      chk("idle_busy", 32'(oBusy), 32'h0);

      // normal load, second iStart in WAIT_BYTE has no effect
      start_pulse();
      chk("arm_state", 32'(oDbgState), 32'(S_WAIT_BYTE));
      chk("arm_busy", 32'(oBusy), 32'h1);
      start_pulse();
      chk("restart_state", 32'(oDbgState), 32'(S_WAIT_BYTE));
      chk("restart_addr", 32'(oAddress), 32'h0);
      pulse_rx(8'hA1); idle(20);
      chk("mid_addr", 32'(oAddress), 32'h1);
      pulse_rx(8'hA2); idle(20);
      pulse_rx(8'hA3); idle(20);
      pulse_rx(8'hA4); idle(20);
      exp_q.push_back({16'd0, 8'hA1});
      exp_q.push_back({16'd1, 8'hA2});
      exp_q.push_back({16'd2, 8'hA3});
      exp_q.push_back({16'd3, 8'hA4});
      chk_writes("load1");
      chk("load1_fin", 32'(fin_cnt), 32'd1);
      chk("load1_addr", 32'(oAddress), 32'h0);
      chk("load1_busy", 32'(oBusy), 32'h0);
      chk("load1_ovr", 32'(oOverrun), 32'h0);

      // pending slot, then overrun in the same load
      fin_cnt = 0;
      start_pulse();
      pulse_rx(8'h11);
      send_now(8'h55);
      idle(10);
      chk("slot_ovr", 32'(oOverrun), 32'h0);
      pulse_rx(8'h77);
      send_now(8'h88);
      send_now(8'h99);
      idle(15);
      exp_q.push_back({16'd0, 8'h11});
      exp_q.push_back({16'd1, 8'h55});
      exp_q.push_back({16'd2, 8'h77});
      exp_q.push_back({16'd3, 8'h88});
      chk_writes("slot");
      chk("ovr_set", 32'(oOverrun), 32'h1);
      chk("slot_fin", 32'(fin_cnt), 32'd1);
      start_pulse();
      chk("ovr_clear", 32'(oOverrun), 32'h0);

      // reset mid-load after two bytes
      pulse_rx(8'h21); idle(5);
      pulse_rx(8'h22); idle(5);
      chk("pre_rst_addr", 32'(oAddress), 32'h2);
      iReset = 1'b0;
      #1;
      chk("mrst_addr", 32'(oAddress), 32'h0);
      chk("mrst_busy", 32'(oBusy), 32'h0);
      chk("mrst_data", 32'(oData), 32'h0);
      chk("mrst_state", 32'(oDbgState), 32'(S_IDLE));
      @(negedge iClock) iReset = 1'b1;
      exp_q.push_back({16'd0, 8'h21});
      exp_q.push_back({16'd1, 8'h22});
      chk_writes("pre_rst");
      start_pulse();
      pulse_rx(8'h31); idle(5);
      exp_q.push_back({16'd0, 8'h31});
      chk_writes("after_rst");
      chk("after_rst_addr", 32'(oAddress), 32'h1);

`ifdef RX_TIMEOUT_EN
      // idle timeout after one byte
      iReset = 1'b0;
      #3;
      @(negedge iClock) iReset = 1'b1;
      fin_cnt = 0;
      start_pulse();
      pulse_rx(8'h42);
      begin
         int cyc;
         cyc = 0;
         while (fin_cnt == 0 && cyc < 300) begin
            idle(1);
            cyc++;
         end
         chk("tmo_seen", 32'(fin_cnt), 32'd1);
         chk("tmo_window", 32'(cyc > 95 && cyc < 110), 32'h1);
      end
      chk("tmo_flag", 32'(oTimeout), 32'h1);
      idle(3);
      chk("tmo_sticky", 32'(oTimeout), 32'h1);
      chk("tmo_busy", 32'(oBusy), 32'h0);
      start_pulse();
      chk("tmo_clear", 32'(oTimeout), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
